// File: rtl/ebr_block_reader.sv
// Streams a block of words out of a registered-read dual-port RAM through a
// two-entry output FIFO with valid/ready handshake and credit-limited issue.
module ebr_block_reader #(
  parameter int addr_width = 9,
  parameter int data_width = 8,
  parameter int len_width  = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [len_width-1:0]  block_len,
  output logic [addr_width-1:0] raddr,
  input  logic [data_width-1:0] ram_dout,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [len_width-1:0]  rem_issue_q, rem_issue_d;
  logic [len_width-1:0]  rem_out_q, rem_out_d;
  logic                  inflight_q, inflight_d;
  logic [data_width-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pop, push, issue;

  assign pop  = (cnt_q != 2'd0) && out_ready;
  assign push = inflight_q;
  // Credit: occupancy + inflight - pop < 2, rearranged to avoid underflow.
  assign issue = (state_q == FETCH) && (rem_issue_q != '0) &&
                 (({1'b0, cnt_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_issue_d = rem_issue_q;
    rem_out_d   = rem_out_q;
    inflight_d  = issue;
    if (pop) rem_out_d = rem_out_q - len_width'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          rem_issue_d = block_len;
          rem_out_d   = block_len;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // A zero-length block passes through FETCH for one cycle so done lands two cycles after start.
        if (rem_issue_q == '0) begin
          state_d = FIN;
        end else if (issue) begin
          addr_d      = addr_q + addr_width'(1);
          rem_issue_d = rem_issue_q - len_width'(1);
          if (rem_issue_q == len_width'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (rem_out_q == len_width'(1))) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) buf0_d = ram_dout;
        else               buf1_d = ram_dout;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          buf0_d = ram_dout;
        end else begin
          buf0_d = buf1_q;
          buf1_d = ram_dout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_issue_q <= '0;
      rem_out_q   <= '0;
      inflight_q  <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_issue_q <= rem_issue_d;
      rem_out_q   <= rem_out_d;
      inflight_q  <= inflight_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      cnt_q       <= cnt_d;
    end
  end

  assign raddr     = addr_q;
  assign out_data  = buf0_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_last  = out_valid && (rem_out_q == len_width'(1));
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);

endmodule

// File: tb/tb_ebr_block_reader.sv
// Directed bench for ebr_block_reader with a registered-read RAM model holding mem[a]=a[7:0].
module tb_ebr_block_reader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] base_addr = '0;
  logic [6:0] block_len = '0;
  logic [8:0] raddr;
  logic [7:0] ram_dout;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [512];

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= mem[raddr];

  ebr_block_reader #(.addr_width(9), .data_width(8), .len_width(7)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .block_len(block_len), .raddr(raddr), .ram_dout(ram_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  // Drives start for one cycle; returns #1 into cycle 1.
  task automatic do_start(input logic [8:0] b, input logic [6:0] l);
    start = 1'b1; base_addr = b; block_len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if ({raddr, out_data, out_valid, out_last, busy, done} !== 21'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {raddr, out_data, out_valid, out_last, busy, done});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_full_rate();
    out_ready = 1'b1;
    do_start(9'h010, 7'd64);
    for (int c = 1; c <= 68; c++) begin
      logic [7:0] exp;
      exp = 8'(8'h10 + c - 3);
      if (c >= 3 && c <= 66) begin
        total++; if (out_valid !== 1'b1 || out_data !== exp) begin
          bad++; $display("FAIL full_data cyc=%0d got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, exp);
        end
      end else begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_idle_valid cyc=%0d got=%b want=0", c, out_valid); end
      end
      total++; if (out_last !== (c == 66)) begin bad++; $display("FAIL full_last cyc=%0d got=%b want=%b", c, out_last, c == 66); end
      total++; if (done !== (c == 67)) begin bad++; $display("FAIL full_done cyc=%0d got=%b want=%b", c, done, c == 67); end
      if (c == 1 || c == 68) begin
        total++; if (busy !== (c == 1)) begin bad++; $display("FAIL full_busy cyc=%0d got=%b want=%b", c, busy, c == 1); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    do_start(9'h1FC, 7'd8);
    for (int c = 1; c <= 11; c++) begin
      logic [8:0] a;
      logic [8:0] ad;
      a  = 9'(9'h1FC + c - 1);
      ad = 9'(9'h1FC + c - 3);
      if (c <= 8) begin
        total++; if (raddr !== a) begin bad++; $display("FAIL wrap_addr cyc=%0d got=%h want=%h", c, raddr, a); end
      end
      if (c >= 3 && c <= 10) begin
        total++; if (out_valid !== 1'b1 || out_data !== ad[7:0]) begin
          bad++; $display("FAIL wrap_data cyc=%0d got v=%b d=%h want d=%h", c, out_valid, out_data, ad[7:0]);
        end
      end
      total++; if (done !== (c == 11)) begin bad++; $display("FAIL wrap_done cyc=%0d got=%b", c, done); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int         idx = 0;
    int         dones = 0;
    logic       stall = 1'b0;
    logic [7:0] held = '0;
    logic [7:0] exp;
    out_ready = 1'b0;
    do_start(9'h080, 7'd64);
    for (int c = 1; c <= 800 && dones == 0; c++) begin
      if (stall) begin
        total++; if (out_valid !== 1'b1 || out_data !== held) begin
          bad++; $display("FAIL bp_stall cyc=%0d got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, held);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        exp = 8'(8'h80 + idx);
        total++; if (out_data !== exp || out_last !== (idx == 63)) begin
          bad++; $display("FAIL bp_word idx=%0d got d=%h l=%b want d=%h l=%b", idx, out_data, out_last, exp, idx == 63);
        end
        idx++;
      end
      stall = out_valid && !out_ready;
      held  = out_data;
      if (done) dones++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    total++; if (idx != 64) begin bad++; $display("FAIL bp_count got=%0d want=64", idx); end
    total++; if (dones != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", dones); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle got busy=%b want=0", busy); end
  endtask

  task automatic test_zero_len();
    out_ready = 1'b1;
    do_start(9'h005, 7'd0);
    for (int c = 1; c <= 4; c++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_valid cyc=%0d got=%b want=0", c, out_valid); end
      total++; if (done !== (c == 2)) begin bad++; $display("FAIL zero_done cyc=%0d got=%b want=%b", c, done, c == 2); end
      total++; if (busy !== (c <= 2)) begin bad++; $display("FAIL zero_busy cyc=%0d got=%b want=%b", c, busy, c <= 2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    out_ready = 1'b1;
    do_start(9'h020, 7'd5);
    for (int c = 1; c <= 12; c++) begin
      logic [7:0] exp;
      exp = 8'(8'h20 + c - 3);
      start = (c == 2);
      base_addr = 9'h040; block_len = 7'd3;
      if (c >= 3 && c <= 7) begin
        total++; if (out_valid !== 1'b1 || out_data !== exp) begin
          bad++; $display("FAIL busy_data cyc=%0d got v=%b d=%h want d=%h", c, out_valid, out_data, exp);
        end
      end
      if (done) begin
        dones++;
        total++; if (c != 8) begin bad++; $display("FAIL busy_done_cycle got=%0d want=8", c); end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++; if (dones != 1) begin bad++; $display("FAIL busy_done_count got=%0d want=1", dones); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL busy_trailing_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    out_ready = 1'b1;
    do_start(9'h000, 7'd20);
    repeat (12) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    total++; if ({raddr, out_data, out_valid, out_last, busy, done} !== 21'd0) begin
      bad++; $display("FAIL midreset_outputs got=%h want=0", {raddr, out_data, out_valid, out_last, busy, done});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midreset_idle got d=%b b=%b want 0", done, busy); end
    do_start(9'h030, 7'd4);
    for (int c = 1; c <= 9; c++) begin
      logic [7:0] exp;
      exp = 8'(8'h30 + c - 3);
      if (c >= 3 && c <= 6) begin
        total++; if (out_valid !== 1'b1 || out_data !== exp || out_last !== (c == 6)) begin
          bad++; $display("FAIL midreset_data cyc=%0d got v=%b d=%h l=%b want d=%h", c, out_valid, out_data, out_last, exp);
        end
      end else begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_extra cyc=%0d got v=%b want 0", c, out_valid); end
      end
      if (done) dones++;
      @(posedge clk); #1;
    end
    total++; if (dones != 1) begin bad++; $display("FAIL midreset_done got=%0d want=1", dones); end
  endtask

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = 8'(a);
    test_reset();
    test_full_rate();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_start_while_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
